din_toggle_ctrl: RTL and testbench
==================================

DIN_TOGGLE_CTRL -- requirements
Module: din_toggle_ctrl

Interface
REQ-001 SHALL have parameter CHANNELS, default 8: number of digital inputs managed (1..32).
REQ-002 SHALL have parameter DEBOUNCE, default 16: consecutive differing scan visits required to accept a new level (1..255).
REQ-003 SHALL have port clk  input  1  the single clock; all state is sampled on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert and active-low.
REQ-005 SHALL have port din  input  CHANNELS  raw asynchronous digital inputs.
REQ-006 SHALL have port cfg_we  input  1  config write strobe, one cycle per write.
REQ-007 SHALL have port cfg_addr  input  5  channel index for the config write.
REQ-008 SHALL have port cfg_mode  input  2  mode code: 00 off, 01 toggle on rising edge, 10 toggle on falling edge, 11 follow the debounced level.
REQ-009 SHALL have port toggled  output  CHANNELS  per-channel output state.
REQ-010 SHALL have port event_valid  output  1  event pending.
REQ-011 SHALL have port event_ready  input  1  consumer accepts the event.
REQ-012 SHALL have port event_chan  output  5  channel that produced the event.
REQ-013 SHALL have port event_level  output  1  new debounced level of that channel.

Function
REQ-014 SHALL pass each din bit through a 2-flop synchronizer (s1, s2) before any use.
REQ-015 SHALL keep one scan pointer ptr: 0..CHANNELS-1, +1 per cycle, wrapping to 0; exactly one channel is visited per cycle.
REQ-016 SHALL freeze ptr (no visit processing) while event_valid=1 and event_ready=0.
REQ-017 SHALL keep per-channel stable level and counter cnt, width clog2(DEBOUNCE+1); on a visit: if s2==stable, cnt<=0; else if cnt+1==DEBOUNCE, stable<=s2, cnt<=0 (accepted edge); else cnt<=cnt+1.
REQ-018 SHALL, on an accepted edge, apply the channel's mode: 00 no change; 01 invert toggled if the new level is 1; 10 invert toggled if the new level is 0; 11 toggled<=new level.
REQ-019 SHALL, on an accepted edge with mode!=00, load event_valid=1, event_chan=ptr, event_level=new level, in the same cycle the edge is accepted.
REQ-020 SHALL clear event_valid on a cycle where event_valid=1 and event_ready=1; a new event from that same cycle's visit SHALL reload the slot (event_valid stays 1).
REQ-021 SHALL hold event_chan and event_level stable while event_valid=1 and event_ready=0.
REQ-022 SHALL, on cfg_we with cfg_addr<CHANNELS, write mode[cfg_addr] and set toggled[cfg_addr] to 0 (modes 00/01/10) or stable[cfg_addr] (mode 11), next cycle.
REQ-023 SHALL ignore cfg_we with cfg_addr>=CHANNELS (no state change).
REQ-024 SHALL, when a config write and an accepted edge hit the same channel in one cycle, update stable/cnt normally, apply REQ-022 to toggled, and emit no event.
REQ-025 SHALL bound latency from a clean din change to toggled at 2 + DEBOUNCE*CHANNELS cycles, excluding stall cycles.
REQ-026 SHALL process a DEBOUNCE=1 setting so that the first differing visit is accepted.

Reset
REQ-027 SHALL on rst_n=0 immediately force toggled=0, event_valid=0, event_chan=0, event_level=0, ptr=0, all cnt=0, stable=0, s1=s2=0, and all modes=01.
REQ-028 SHALL resume scanning at ptr=0 on the first clk edge after rst_n returns to 1; reset mid-debounce or mid-stall discards all progress and any pending event.

Verification (CHANNELS=4, DEBOUNCE=3 unless noted)
REQ-029 SHALL cover: din[0] 0->1 held -> toggled[0]=1 within 2+12 cycles; one event with chan=0, level=1; a later 1->0 leaves toggled[0]=1.
REQ-030 SHALL cover: din[2] high for 2 visits then low -> toggled unchanged, no event, cnt[2] returns to 0.
REQ-031 SHALL cover: mode[1]=10, din[1] pulsed 0->1->0 with long holds -> toggled[1] becomes 1 only after the falling edge; 2 events (levels 1, 0).
REQ-032 SHALL cover: event_ready=0, din[0] and din[3] rise together -> event chan 0 held, ptr frozen; after ready=1, chan 3 follows; no event lost, toggled[3]=1.
REQ-033 SHALL cover: cfg_we to ch0 with mode 11 in the same cycle ch0 accepts rising edge -> toggled[0]=1 (stable), no event; cfg_addr=7 -> no effect.
REQ-034 SHALL cover: rst_n low mid-debounce with event pending -> all outputs 0 at once; after release, modes=01 and scanning restarts at ptr=0.

Source files
------------

// File: rtl/din_toggle_ctrl.sv
// Scanned debouncer for CHANNELS digital inputs with per-channel toggle/follow modes
// and a single-entry event slot drained through a valid/ready handshake.
module din_toggle_ctrl #(
  parameter int CHANNELS = 8,
  parameter int DEBOUNCE = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] din,
  input  logic                cfg_we,
  input  logic [4:0]          cfg_addr,
  input  logic [1:0]          cfg_mode,
  output logic [CHANNELS-1:0] toggled,
  output logic                event_valid,
  input  logic                event_ready,
  output logic [4:0]          event_chan,
  output logic                event_level
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);
  localparam logic [4:0]    PTR_LAST = 5'(CHANNELS - 1);
  localparam logic [1:0]    MODE_OFF    = 2'b00;
  localparam logic [1:0]    MODE_RISE   = 2'b01;
  localparam logic [1:0]    MODE_FALL   = 2'b10;
  localparam logic [1:0]    MODE_FOLLOW = 2'b11;

  logic [CHANNELS-1:0] s1_q, s1_d, s2_q, s2_d;
  logic [CHANNELS-1:0] stable_q, stable_d;
  logic [CHANNELS-1:0] toggled_q, toggled_d;
  logic [CW-1:0]       cnt_q [CHANNELS];
  logic [CW-1:0]       cnt_d [CHANNELS];
  logic [1:0]          mode_q [CHANNELS];
  logic [1:0]          mode_d [CHANNELS];
  logic [4:0]          ptr_q, ptr_d;
  logic                event_valid_q, event_valid_d;
  logic [4:0]          event_chan_q, event_chan_d;
  logic                event_level_q, event_level_d;
  logic                visit;

  // A pending event that is not being taken freezes the scan.
  assign visit = !(event_valid_q && !event_ready);

  always_comb begin
    s1_d          = din;
    s2_d          = s1_q;
    stable_d      = stable_q;
    toggled_d     = toggled_q;
    cnt_d         = cnt_q;
    mode_d        = mode_q;
    event_valid_d = event_valid_q && !event_ready;
    event_chan_d  = event_chan_q;
    event_level_d = event_level_q;
    ptr_d         = ptr_q;

    for (int i = 0; i < CHANNELS; i++) begin
      if (visit && (ptr_q == 5'(i))) begin
        if (s2_q[i] == stable_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = s2_q[i];
          cnt_d[i]    = '0;
          case (mode_q[i])
            MODE_RISE:   if (s2_q[i])  toggled_d[i] = ~toggled_q[i];
            MODE_FALL:   if (!s2_q[i]) toggled_d[i] = ~toggled_q[i];
            MODE_FOLLOW: toggled_d[i] = s2_q[i];
            default:     toggled_d[i] = toggled_q[i];
          endcase
          // A config write to the same channel overrides the edge and swallows its event.
          if ((mode_q[i] != MODE_OFF) && !(cfg_we && (cfg_addr == 5'(i)))) begin
            event_valid_d = 1'b1;
            event_chan_d  = 5'(i);
            event_level_d = s2_q[i];
          end
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end

      if (cfg_we && (cfg_addr == 5'(i))) begin
        mode_d[i]    = cfg_mode;
        toggled_d[i] = (cfg_mode == MODE_FOLLOW) ? stable_d[i] : 1'b0;
      end
    end

    if (visit) begin
      ptr_d = (ptr_q == PTR_LAST) ? 5'd0 : ptr_q + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q          <= '0;
      s2_q          <= '0;
      stable_q      <= '0;
      toggled_q     <= '0;
      cnt_q         <= '{default: '0};
      mode_q        <= '{default: MODE_RISE};
      ptr_q         <= '0;
      event_valid_q <= 1'b0;
      event_chan_q  <= '0;
      event_level_q <= 1'b0;
    end else begin
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      stable_q      <= stable_d;
      toggled_q     <= toggled_d;
      cnt_q         <= cnt_d;
      mode_q        <= mode_d;
      ptr_q         <= ptr_d;
      event_valid_q <= event_valid_d;
      event_chan_q  <= event_chan_d;
      event_level_q <= event_level_d;
    end
  end

  assign toggled     = toggled_q;
  assign event_valid = event_valid_q;
  assign event_chan  = event_chan_q;
  assign event_level = event_level_q;

endmodule

// File: tb/tb_din_toggle_ctrl.sv
// Bench for din_toggle_ctrl (4 channels, debounce 3): directed scenarios plus random
// traffic, checked against a cycle-level reference model and an event scoreboard.
module tb_din_toggle_ctrl;

  localparam int CH  = 4;
  localparam int DEB = 3;

  logic          clk;
  logic          rst_n;
  logic [CH-1:0] din;
  logic          cfg_we;
  logic [4:0]    cfg_addr;
  logic [1:0]    cfg_mode;
  logic [CH-1:0] toggled;
  logic          event_valid;
  logic          event_ready;
  logic [4:0]    event_chan;
  logic          event_level;

  din_toggle_ctrl #(.CHANNELS(CH), .DEBOUNCE(DEB)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_mode(cfg_mode), .toggled(toggled), .event_valid(event_valid),
    .event_ready(event_ready), .event_chan(event_chan), .event_level(event_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_pop = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: plain per-channel state updated once per clock from the rules.
  typedef struct {int chan; int lvl;} ev_t;
  ev_t           exp_q[$];
  logic [CH-1:0] m_s1, m_s2, m_stab, m_tog;
  int            m_cnt [CH];
  int            m_mode [CH];
  int            m_ptr;
  bit            m_pend;
  int            m_chan, m_lvl;

  always @(posedge clk or negedge rst_n) begin
    bit stall;
    int p, lv, ca;
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_stab = '0; m_tog = '0;
      for (int i = 0; i < CH; i++) begin m_cnt[i] = 0; m_mode[i] = 1; end
      m_ptr = 0; m_pend = 0; m_chan = 0; m_lvl = 0;
      exp_q.delete();
    end else begin
      ca    = int'(cfg_addr);
      stall = m_pend && !event_ready;
      if (m_pend && event_ready) m_pend = 0;
      if (!stall) begin
        p = m_ptr;
        if (m_s2[p] == m_stab[p]) m_cnt[p] = 0;
        else if (m_cnt[p] + 1 == DEB) begin
          m_stab[p] = m_s2[p];
          m_cnt[p]  = 0;
          lv        = int'(m_s2[p]);
          case (m_mode[p])
            1: if (lv == 1) m_tog[p] = ~m_tog[p];
            2: if (lv == 0) m_tog[p] = ~m_tog[p];
            3: m_tog[p] = m_s2[p];
            default: ;
          endcase
          if (m_mode[p] != 0 && !(cfg_we && ca == p)) begin
            m_pend = 1; m_chan = p; m_lvl = lv;
            exp_q.push_back('{chan: p, lvl: lv});
          end
        end else m_cnt[p]++;
        m_ptr = (m_ptr + 1) % CH;
      end
      if (cfg_we && ca < CH) begin
        m_mode[ca] = int'(cfg_mode);
        m_tog[ca]  = (cfg_mode == 2'b11) ? m_stab[ca] : 1'b0;
      end
      m_s2 = m_s1;
      m_s1 = din;
    end
  end

  // Monitor: compares outputs against the model and drains the scoreboard on handshakes.
  always @(negedge clk) begin
    ev_t e;
    if (rst_n) begin
      chk("toggled", int'(toggled), int'(m_tog));
      chk("event_valid", int'(event_valid), int'(m_pend));
      if (event_valid && m_pend) begin
        chk("event_chan_hold", int'(event_chan), m_chan);
        chk("event_level_hold", int'(event_level), m_lvl);
      end
      if (event_valid && event_ready) begin
        chk("sb_nonempty", (exp_q.size() > 0) ? 1 : 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          n_pop++;
          chk("sb_chan", int'(event_chan), e.chan);
          chk("sb_level", int'(event_level), e.lvl);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    bit found;
    int pops0;
    logic [CH-1:0] snap;

    rst_n = 1'b0; din = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_mode = '0; event_ready = 1'b1;
    cyc(2);
    chk("rst_toggled", int'(toggled), 0);
    chk("rst_valid", int'(event_valid), 0);
    chk("rst_chan", int'(event_chan), 0);
    chk("rst_level", int'(event_level), 0);
    rst_n = 1'b1;
    cyc(5);

    // Rising edge on ch0 reaches toggled within 2 + DEB*CH cycles.
    din[0] = 1'b1;
    found = 0;
    for (int k = 0; k < 2 + DEB * CH && !found; k++) begin
      cyc(1);
      if (toggled[0]) found = 1;
    end
    chk("r029_latency", int'(found), 1);
    cyc(20);
    din[0] = 1'b0;
    cyc(20);
    chk("r029_fall_keeps", int'(toggled[0]), 1);

    // Glitch spanning only two visits of ch2 is rejected.
    din[2] = 1'b1;
    cyc(8);
    din[2] = 1'b0;
    cyc(20);
    chk("r030_no_toggle", int'(toggled[2]), 0);
    chk("r030_no_event", int'(event_valid), 0);

    // Falling-edge mode on ch1.
    cfg_we = 1'b1; cfg_addr = 5'd1; cfg_mode = 2'b10;
    cyc(1);
    cfg_we = 1'b0;
    pops0 = n_pop;
    din[1] = 1'b1;
    cyc(20);
    chk("r031_after_rise", int'(toggled[1]), 0);
    din[1] = 1'b0;
    cyc(20);
    chk("r031_after_fall", int'(toggled[1]), 1);
    chk("r031_events", n_pop - pops0, 2);

    // Stall: ch0 and ch3 rise together, phase chosen so ch0 is accepted first.
    found = 0;
    for (int k = 0; k < 8 && !found; k++) begin
      if (m_ptr == 2) found = 1; else cyc(1);
    end
    chk("r032_align", int'(found), 1);
    event_ready = 1'b0;
    din[0] = 1'b1; din[3] = 1'b1;
    cyc(20);
    chk("r032_valid", int'(event_valid), 1);
    chk("r032_chan", int'(event_chan), 0);
    chk("r032_level", int'(event_level), 1);
    event_ready = 1'b1;
    cyc(20);
    chk("r032_tog3", int'(toggled[3]), 1);
    chk("r032_drained", exp_q.size(), 0);

    // Config write to ch0 in the very cycle its rising edge is accepted.
    din[0] = 1'b0;
    cyc(20);
    din[0] = 1'b1;
    found = 0;
    for (int k = 0; k < 30 && !found; k++) begin
      cyc(1);
      if (m_ptr == 0 && m_s2[0] != m_stab[0] && m_cnt[0] == DEB - 1 && !m_pend) found = 1;
    end
    chk("r033_align", int'(found), 1);
    cfg_we = 1'b1; cfg_addr = 5'd0; cfg_mode = 2'b11;
    cyc(1);
    cfg_we = 1'b0;
    chk("r033_follow", int'(toggled[0]), 1);
    chk("r033_no_event", int'(event_valid), 0);
    snap = m_tog;
    cfg_we = 1'b1; cfg_addr = 5'd7; cfg_mode = 2'b00;
    cyc(1);
    cfg_we = 1'b0;
    cyc(1);
    chk("r033_addr7", int'(toggled), int'(snap));

    // Reset mid-debounce with an event pending.
    event_ready = 1'b0;
    din[3] = 1'b0;
    cyc(20);
    chk("r034_pending", int'(event_valid), 1);
    din[1] = 1'b1;
    cyc(5);
    rst_n = 1'b0; din = '0; event_ready = 1'b1;
    #1;
    chk("r034_toggled", int'(toggled), 0);
    chk("r034_valid", int'(event_valid), 0);
    chk("r034_chan", int'(event_chan), 0);
    chk("r034_level", int'(event_level), 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(20);
    chk("r034_quiet", int'(toggled), 0);
    din[0] = 1'b1;
    cyc(20);
    din[0] = 1'b0;
    cyc(20);
    chk("r034_mode01", int'(toggled[0]), 1);

    // Random traffic.
    for (int k = 0; k < 2500; k++) begin
      if ($urandom_range(0, 23) == 0) din = din ^ (4'b0001 << $urandom_range(0, 3));
      event_ready = ($urandom_range(0, 3) != 0);
      cfg_we = ($urandom_range(0, 39) == 0);
      cfg_addr = 5'($urandom_range(0, 7));
      cfg_mode = 2'($urandom_range(0, 3));
      cyc(1);
    end
    cfg_we = 1'b0;
    event_ready = 1'b1;
    cyc(60);
    chk("sb_drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
